// File: rtl/upg_frame_loader.sv
// Purpose : parses framed download packets from a UART byte stream and issues word writes to a selected memory.
// Latency : wen_o fires the cycle after the last byte of a word; the response goes valid the cycle after the frame ends.
// Backpr. : none on rx (one byte per strobe, no stall); tx_valid_o/tx_data_o are held until tx_ready_i.
//
// Frame   : SYNC_BYTE, target index, count lo, count hi, then count words of DATA_W/8 bytes, LSB first.
// Option  : define UPG_LOADER_CSUM_EN to require a trailing 8-bit additive checksum byte
//           (sum of target byte through last payload byte).
// Ports   : upg_clk_i/upg_rst_i      clock, async active-high reset
//           rx_data_i/rx_valid_i     received byte and its one-cycle strobe
//           wen_o/addr_o/data_o/tgt_o word write strobe, word address, word, one-hot target
//           done_o/err_o             one-cycle pulse on ACK / NAK
//           busy_o                   high while a frame or its response is in progress
//           tx_data_o/tx_valid_o/tx_ready_i  response byte (55 ACK, EE NAK) handshake
module upg_frame_loader #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned NUM_TARGETS = 2,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                   upg_clk_i,
    input  logic                   upg_rst_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   wen_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [NUM_TARGETS-1:0] tgt_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i
);

    localparam int unsigned BPW    = DATA_W / 8;
    localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]        NUM_TGT_B = 8'(NUM_TARGETS);
    localparam logic [7:0]        ACK_BYTE  = 8'h55;
    localparam logic [7:0]        NAK_BYTE  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TGT,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef UPG_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_RESP
    } state_t;

    state_t              state, state_nx;
    logic [7:0]          len_lo;
    logic [15:0]         len;
    logic [15:0]         word_cnt;
    logic [BIDX_W-1:0]   byte_idx;
    logic [TMO_W-1:0]    tmo_cnt;
`ifdef UPG_LOADER_CSUM_EN
    logic [7:0]          csum;
`endif

    logic go_resp;
    logic resp_ack;
    logic byte_acc;
    logic in_frame;
    logic tmo_hit;
    logic last_byte;

    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        go_resp   = 1'b0;
        resp_ack  = 1'b0;
        byte_acc  = 1'b0;
        in_frame  = (state != S_IDLE) && (state != S_RESP);
        // A byte arriving on the expiry cycle wins over the timeout.
        tmo_hit   = in_frame && !rx_valid_i && (tmo_cnt == TMO_LAST);
        last_byte = (byte_idx == LAST_BYTE);

        case (state)
            S_IDLE: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE)) state_nx = S_TGT;
            end
            S_TGT: begin
                if (rx_valid_i) begin
                    if (rx_data_i >= NUM_TGT_B) go_resp = 1'b1;
                    else                        state_nx = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid_i) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (rx_valid_i) begin
                    if ({rx_data_i, len_lo} == 16'd0) begin
`ifdef UPG_LOADER_CSUM_EN
                        state_nx = S_CSUM;
`else
                        go_resp  = 1'b1;
                        resp_ack = 1'b1;
`endif
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // word_cnt == len only in the write cycle of the final word:
                // leave once that strobe is out and drop any stray byte.
                if (word_cnt == len) begin
                    go_resp  = 1'b1;
                    resp_ack = 1'b1;
                end else if (rx_valid_i) begin
                    byte_acc = 1'b1;
`ifdef UPG_LOADER_CSUM_EN
                    // Move on immediately so a checksum byte sent back-to-back
                    // with the final write strobe is not lost.
                    if (last_byte && (word_cnt + 16'd1 == len)) state_nx = S_CSUM;
`endif
                end
            end
`ifdef UPG_LOADER_CSUM_EN
            S_CSUM: begin
                if (rx_valid_i) begin
                    go_resp  = 1'b1;
                    resp_ack = (rx_data_i == csum);
                end
            end
`endif
            S_RESP: begin
                if (tx_ready_i) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (tmo_hit) begin
            go_resp  = 1'b1;
            resp_ack = 1'b0;
        end
        if (go_resp) state_nx = S_RESP;
    end

    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            wen_o      <= 1'b0;
            addr_o     <= '0;
            data_o     <= '0;
            tgt_o      <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            len_lo     <= 8'h00;
            len        <= 16'd0;
            word_cnt   <= 16'd0;
            byte_idx   <= '0;
            tmo_cnt    <= '0;
`ifdef UPG_LOADER_CSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            wen_o  <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;

            if (!in_frame || rx_valid_i) tmo_cnt <= '0;
            else                         tmo_cnt <= tmo_cnt + 1'b1;

            if ((state == S_TGT) && rx_valid_i && (rx_data_i < NUM_TGT_B))
                tgt_o <= NUM_TARGETS'(1) << rx_data_i;

            if ((state == S_LEN_LO) && rx_valid_i) len_lo <= rx_data_i;

            if ((state == S_LEN_HI) && rx_valid_i) begin
                len      <= {rx_data_i, len_lo};
                word_cnt <= 16'd0;
                byte_idx <= '0;
                addr_o   <= '0;
            end else if (wen_o) begin
                // Address advances after the write cycle so addr_o is stable during it.
                addr_o <= addr_o + 1'b1;
            end

            if (byte_acc) begin
                data_o[{byte_idx, 3'b000} +: 8] <= rx_data_i;
                if (last_byte) begin
                    byte_idx <= '0;
                    word_cnt <= word_cnt + 16'd1;
                    wen_o    <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end

`ifdef UPG_LOADER_CSUM_EN
            if (state == S_IDLE)
                csum <= 8'h00;
            else if (rx_valid_i && ((state == S_TGT) || (state == S_LEN_LO) ||
                                    (state == S_LEN_HI) || byte_acc))
                csum <= csum + rx_data_i;
`endif

            if (go_resp) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= resp_ack ? ACK_BYTE : NAK_BYTE;
                done_o     <= resp_ack;
                err_o      <= !resp_ack;
            end else if ((state == S_RESP) && tx_ready_i) begin
                tx_valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state != S_IDLE);

endmodule
